// File: rtl/vga_ctrl_pkg.sv
// Shared VGA timing constants, colours and small helpers for vga_ctrl and the
// vga_pic* picture generators.
package vga_ctrl_pkg;

  // 640x480@60Hz horizontal timing, in pixel clocks
  localparam logic [9:0] H_SYNC  = 10'd96;
  localparam logic [9:0] H_BACK  = 10'd48;
  localparam logic [9:0] H_VALID = 10'd640;
  localparam logic [9:0] H_FRONT = 10'd16;
  localparam logic [9:0] H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;

  // vertical timing, in lines
  localparam logic [9:0] V_SYNC  = 10'd2;
  localparam logic [9:0] V_BACK  = 10'd33;
  localparam logic [9:0] V_VALID = 10'd480;
  localparam logic [9:0] V_FRONT = 10'd10;
  localparam logic [9:0] V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  // sync level while the pulse is asserted (0 = active-low)
  localparam logic SYNC_POL = 1'b0;

  // RGB565 colours
  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] BLACK = 16'h0000;

  // coordinate value meaning "no pixel requested"
  localparam logic [9:0] PIX_NONE = 10'h3FF;

  // pixel request coordinate handed to the picture generator
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pix_pos_t;

  // half-open interval test: lo <= val < hi
  function automatic logic in_span(input logic [9:0] val,
                                   input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_wrap_cnt.sv
// Modulo-MAX counter with an enable; wrap is high on the enabled clock that
// takes the count from MAX-1 back to 0, so it can enable the next stage.
module vga_wrap_cnt #(
  parameter logic [9:0] MAX = 10'd800
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] cnt,
  output logic       wrap
);

  assign wrap = en && (cnt == MAX - 10'd1);

  // count on enable, return to zero on the terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (wrap) cnt <= '0;
    else if (en)   cnt <= cnt + 10'd1;
  end

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator. Requests pixels one clock ahead of the active window
// so the generator's registered pix_data arrives exactly on the displayed
// pixel, then blanks it outside the window and drives the sync lines.
module vga_ctrl #(
  parameter logic [9:0] H_SYNC   = vga_ctrl_pkg::H_SYNC,
  parameter logic [9:0] H_BACK   = vga_ctrl_pkg::H_BACK,
  parameter logic [9:0] H_VALID  = vga_ctrl_pkg::H_VALID,
  parameter logic [9:0] H_FRONT  = vga_ctrl_pkg::H_FRONT,
  parameter logic [9:0] V_SYNC   = vga_ctrl_pkg::V_SYNC,
  parameter logic [9:0] V_BACK   = vga_ctrl_pkg::V_BACK,
  parameter logic [9:0] V_VALID  = vga_ctrl_pkg::V_VALID,
  parameter logic [9:0] V_FRONT  = vga_ctrl_pkg::V_FRONT,
  parameter logic       SYNC_POL = vga_ctrl_pkg::SYNC_POL
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        rgb_valid,
  output logic        frame_start
);
  import vga_ctrl_pkg::*;

  localparam logic [9:0] H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam logic [9:0] V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  // first active column / row, counted from the start of the sync pulse
  localparam logic [9:0] HA = H_SYNC + H_BACK;
  localparam logic [9:0] VA = V_SYNC + V_BACK;

  logic [9:0] cnt_h, cnt_v;
  logic       h_wrap, v_wrap;
  logic       h_act, h_req, v_act;
  pix_pos_t   req_pos;

  vga_wrap_cnt #(.MAX(H_TOTAL)) u_cnt_h (
    .clk  (vga_clk),
    .rst  (sys_rst),
    .en   (1'b1),
    .cnt  (cnt_h),
    .wrap (h_wrap)
  );

  // the line counter steps on the horizontal wrap, so both wrap together
  // on the last pixel of the last line
  vga_wrap_cnt #(.MAX(V_TOTAL)) u_cnt_v (
    .clk  (vga_clk),
    .rst  (sys_rst),
    .en   (h_wrap),
    .cnt  (cnt_v),
    .wrap (v_wrap)
  );

  // one-clock pulse on the cycle the counters come back to (0,0)
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) frame_start <= 1'b0;
    else         frame_start <= v_wrap;
  end

  // window decode: the request window leads the active window by one clock
  always_comb begin
    h_act = in_span(cnt_h, HA, HA + H_VALID);
    h_req = in_span(cnt_h, HA - 10'd1, HA + H_VALID - 10'd1);
    v_act = in_span(cnt_v, VA, VA + V_VALID);
  end

  // pixel request coordinates, parked at PIX_NONE outside the request window
  always_comb begin
    req_pos.x = PIX_NONE;
    req_pos.y = PIX_NONE;
    if (h_req && v_act) begin
      req_pos.x = cnt_h - (HA - 10'd1);
      req_pos.y = cnt_v - VA;
    end
  end

  assign pix_x = req_pos.x;
  assign pix_y = req_pos.y;

  // sync pulses and blanked pixel output
  always_comb begin
    hsync     = (cnt_h < H_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync     = (cnt_v < V_SYNC) ? SYNC_POL : ~SYNC_POL;
    rgb_valid = h_act && v_act;
    rgb       = rgb_valid ? pix_data : BLACK;
  end

endmodule
